cell_scan_controller: RTL
=========================

# cell_scan_controller

Sequencer that walks a CELL_N×CELL_N window across an rxImage-sized frame and feeds the cell processor one cell at a time. It generates each cell's window coordinates, issues them to the cell processor with the latched opcode and user input, and tracks outstanding results with a credit counter. It also produces the txImage write coordinates for each returned center-pixel result. It sits between the frame-level instruction source and the cell processor datapath.

## Interface
- IMG_W, 640, frame width in pixels
- IMG_H, 480, frame height in pixels
- CELL_N, 3, window edge; odd, ≥3
- OPCODE_W, 4, opcode width
- CH_W, 8, user-input width
- MAX_OUT, 4, maximum cells in flight inside the cell processor (power of 2, ≤16)
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin a frame; sampled only in IDLE
- opcode_in  in  OPCODE_W  operation for the frame
- user_in  in  CH_W  immediate operand for the frame
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at frame end
- err  out  1  sticky illegal-opcode flag; cleared by the next accepted start
- iss_valid  out  1  cell request valid
- iss_ready  in  1  cell processor accepts the request
- iss_x, iss_y  out  $clog2(IMG_W), $clog2(IMG_H)  top-left corner of the window
- iss_opcode, iss_user  out  OPCODE_W, CH_W  latched frame values
- res_valid  in  1  cell processor result valid
- res_ready  out  1  equals wr_ready while busy, 0 in IDLE
- wr_ready  in  1  frame writer can take a pixel
- wr_en  out  1  res_valid && res_ready
- wr_x, wr_y  out  as iss_x/iss_y  txImage coordinate of the current result
- perf_stall  out  32  stall-cycle count (see Configuration)

## Operation
- Cell grid: GX = IMG_W−CELL_N+1 columns and GY = IMG_H−CELL_N+1 rows, visited in raster order with x fastest. Total cells N = GX·GY.
- States: IDLE, ISSUE, DRAIN, DONE.
  - IDLE: when start=1, latch opcode_in and user_in, clear err, zero all counters. If the opcode is ≥ 11 (beyond NOR), set err and go to DONE with nothing issued. Otherwise go to ISSUE.
  - ISSUE: iss_valid = (outstanding < MAX_OUT). On an iss_valid && iss_ready handshake, advance iss_x; on wrap (iss_x = GX−1) set iss_x to 0 and increment iss_y. After the handshake of cell N−1, go to DRAIN.
  - DRAIN: iss_valid = 0. When outstanding = 0 and the write count = N, go to DONE.
  - DONE: done = 1 for one cycle, then IDLE.
- outstanding: +1 on an issue handshake, −1 on a result handshake, unchanged when both occur in the same cycle. It never exceeds MAX_OUT and never underflows; a result arriving while outstanding = 0 is a protocol error, is ignored, and causes no wr_en.
- wr_x/wr_y use a separate raster counter over GX×GY that advances on each result handshake. Results are in-order.
- iss_x, iss_y, iss_opcode and iss_user stay stable while iss_valid=1 and iss_ready=0.
- start while busy is ignored.

## Timing
- Reset values: state IDLE; busy, done, err, iss_valid, res_ready, wr_en = 0; all coordinates, outstanding and perf_stall = 0.
- start sampled in cycle t: busy=1 and iss_valid=1 in cycle t+1 with iss_x=iss_y=0.
- Maximum issue rate is 1 cell/clock while credits remain.
- wr_en is combinational from res_valid && wr_ready. wr_x/wr_y are registered and already reflect the current result.
- Last result handshake in cycle t: DONE in t+1 (done=1), IDLE in t+2.
- Illegal opcode: DONE one cycle after start; done=1 with err=1.
- Reset asserted mid-frame: next cycle is IDLE with all counters zero. Later res_valid is not accepted because res_ready=0.

## Configuration
- CELL_SCAN_PERF_EN defined: perf_stall counts cycles in ISSUE where iss_valid=1 and iss_ready=0, plus cycles where iss_valid=0 only because outstanding = MAX_OUT. It is cleared on an accepted start and saturates at 2^32−1.
- Not defined: perf_stall is tied to 0 and the counter logic is absent.

## Test plan
- IMG_W=5, IMG_H=4, iss_ready=1, 2-cycle-latency processor model, wr_ready=1 → 6 issues at (0,0)(1,0)(2,0)(0,1)(1,1)(2,1), 6 wr_en with matching wr_x/wr_y, done exactly once.
- MAX_OUT=2, processor holds results 10 cycles → iss_valid drops after 2 issues. With PERF_EN, perf_stall equals the total stall cycles.
- Random iss_ready and wr_ready backpressure → iss_*/wr_* stable while stalled, no lost or duplicated coordinates, outstanding always in 0..MAX_OUT.
- opcode_in=4'hF at start → err=1, done one cycle later, zero issues. The next start with ADD clears err.
- Reset at the 3rd issue → IDLE next cycle, busy=0. Stray res_valid gives no wr_en. The following start rescans from (0,0).
- start pulsed during ISSUE → ignored: the latched opcode and user input are unchanged and the cell count is still N.

Source files
------------

// File: rtl/cell_scan_controller.sv
// cell_scan_controller
//   Walks a CELL_N x CELL_N window across an IMG_W x IMG_H frame in raster
//   order (x fastest). It issues one window corner per handshake to the cell
//   processor and tracks results in flight with a credit counter. It also
//   produces the txImage write coordinate for each returned result.
//
// Ports
//   clock, reset            system clock, synchronous active-high reset
//   start, opcode_in,       frame command, accepted only in IDLE
//   user_in
//   busy, done, err         status: not-IDLE, end-of-frame pulse,
//                           sticky illegal-opcode flag
//   iss_valid/iss_ready     cell request handshake carrying
//   iss_x/iss_y             the window corner, plus the latched
//   iss_opcode/iss_user     frame opcode and user operand
//   res_valid/res_ready     cell result handshake (in-order results)
//   wr_ready, wr_en,        pixel writer handshake and the txImage
//   wr_x/wr_y               coordinate of the current result
//   perf_stall              issue stall counter
//
// Optional feature: define CELL_SCAN_PERF_EN to build the stall counter.
// Without it, perf_stall is tied to zero.
module cell_scan_controller #(
   parameter int IMG_W    = 640,
   parameter int IMG_H    = 480,
   parameter int CELL_N   = 3,
   parameter int OPCODE_W = 4,
   parameter int CH_W     = 8,
   parameter int MAX_OUT  = 4
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       start,
   input  logic [OPCODE_W-1:0]        opcode_in,
   input  logic [CH_W-1:0]            user_in,
   output logic                       busy,
   output logic                       done,
   output logic                       err,
   output logic                       iss_valid,
   input  logic                       iss_ready,
   output logic [$clog2(IMG_W)-1:0]   iss_x,
   output logic [$clog2(IMG_H)-1:0]   iss_y,
   output logic [OPCODE_W-1:0]        iss_opcode,
   output logic [CH_W-1:0]            iss_user,
   input  logic                       res_valid,
   output logic                       res_ready,
   input  logic                       wr_ready,
   output logic                       wr_en,
   output logic [$clog2(IMG_W)-1:0]   wr_x,
   output logic [$clog2(IMG_H)-1:0]   wr_y,
   output logic [31:0]                perf_stall
);
   localparam int XW = $clog2(IMG_W);
   localparam int YW = $clog2(IMG_H);
   localparam int GX = IMG_W - CELL_N + 1;
   localparam int GY = IMG_H - CELL_N + 1;
   localparam int OW = $clog2(MAX_OUT) + 1;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} stateType;

   stateType        state;
   logic [OW-1:0]   outstanding;
   logic            issFire, resFire, issLast, wrLast, creditsFull;

   assign creditsFull = (outstanding == OW'(MAX_OUT));
   assign busy        = (state != IDLE);
   assign done        = (state == DONE);
   assign iss_valid   = (state == ISSUE) && !creditsFull;
   assign res_ready   = busy && wr_ready;
   // A result with nothing in flight is a protocol error: drop it silently.
   assign resFire     = res_valid && res_ready && (outstanding != '0);
   assign wr_en       = resFire;
   assign issFire     = iss_valid && iss_ready;
   assign issLast     = (iss_x == XW'(GX - 1)) && (iss_y == YW'(GY - 1));
   assign wrLast      = (wr_x == XW'(GX - 1)) && (wr_y == YW'(GY - 1));

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         err         <= 1'b0;
         iss_x       <= '0;
         iss_y       <= '0;
         wr_x        <= '0;
         wr_y        <= '0;
         outstanding <= '0;
         iss_opcode  <= '0;
         iss_user    <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               iss_opcode  <= opcode_in;
               iss_user    <= user_in;
               iss_x       <= '0;
               iss_y       <= '0;
               wr_x        <= '0;
               wr_y        <= '0;
               outstanding <= '0;
               // Opcodes above NOR (10) are undefined.
               if (32'(opcode_in) >= 32'd11) begin
                  err   <= 1'b1;
                  state <= DONE;
               end else begin
                  err   <= 1'b0;
                  state <= ISSUE;
               end
            end
            ISSUE: if (issFire) begin
               if (iss_x == XW'(GX - 1)) begin
                  iss_x <= '0;
                  iss_y <= iss_y + YW'(1);
               end else begin
                  iss_x <= iss_x + XW'(1);
               end
               if (issLast) state <= DRAIN;
            end
            // Every cell is issued and results are in order, so the final
            // write coordinate marks the last result.
            DRAIN: if (resFire && wrLast) state <= DONE;
            DONE:  state <= IDLE;
            default: state <= IDLE;
         endcase

         if (resFire) begin
            if (wr_x == XW'(GX - 1)) begin
               wr_x <= '0;
               wr_y <= wr_y + YW'(1);
            end else begin
               wr_x <= wr_x + XW'(1);
            end
         end

         // Nothing fires in IDLE, so this never fights the start-time clear.
         if (issFire && !resFire)      outstanding <= outstanding + OW'(1);
         else if (!issFire && resFire) outstanding <= outstanding - OW'(1);
      end
   end

`ifdef CELL_SCAN_PERF_EN
   logic [31:0] stallCnt;
   always_ff @(posedge clock) begin
      if (reset)
         stallCnt <= '0;
      else if (state == IDLE && start)
         stallCnt <= '0;
      else if (state == ISSUE && ((iss_valid && !iss_ready) || creditsFull)
               && stallCnt != '1)
         stallCnt <= stallCnt + 32'd1;
   end
   assign perf_stall = stallCnt;
`else
   assign perf_stall = '0;
`endif

endmodule
